// File: rtl/test_status_monitor.sv
// Consumer of a bench's fail/finish pair: enforces a run timeout, waits a settle
// window for late failures, then latches a sticky pass/fail/timeout verdict.
module test_status_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fail,
    input  logic             finish,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SET_INIT    = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
    localparam bit          HAS_TIMEOUT = (TIMEOUT_CYCLES != 0);
    localparam bit          NO_SETTLE   = (SETTLE_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_RUNNING = 2'b00;
    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cycles_q;
    logic             fail_seen_q;
    logic [SET_W-1:0] settle_q;
    logic             done_q;
    logic             pass_q;
    logic             timeout_q;
    logic [1:0]       status_q;

    // Failure including this cycle's sample, so a same-cycle fail counts in the verdict
    logic fail_any_c;
    assign fail_any_c = fail_seen_q | fail;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_RUN;
            cycles_q    <= '0;
            fail_seen_q <= 1'b0;
            settle_q    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            status_q    <= ST_RUNNING;
        end else begin
            case (state_q)
                S_RUN: begin
                    fail_seen_q <= fail_any_c;
                    if (finish) begin
                        if (NO_SETTLE) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            pass_q   <= ~fail_any_c;
                            status_q <= fail_any_c ? ST_FAIL : ST_PASS;
                        end else begin
                            state_q  <= S_SETTLE;
                            settle_q <= SET_W'(SET_INIT);
                        end
                    end else if (HAS_TIMEOUT && (cycles_q == TO_LAST)) begin
                        // Timeout outranks a same-cycle fail in the reported status
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        status_q  <= ST_TIMEOUT;
                    end else if (cycles_q != CNT_MAX) begin
                        cycles_q <= cycles_q + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    fail_seen_q <= fail_any_c;
                    if (settle_q == '0) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        pass_q   <= ~fail_any_c;
                        status_q <= fail_any_c ? ST_FAIL : ST_PASS;
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign done    = done_q;
    assign pass    = pass_q;
    assign timeout = timeout_q;
    assign status  = status_q;
    assign cycles  = cycles_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Scoreboard bench: stimulus pushes expected verdicts, per-DUT monitors pop and
// compare on each rising done.
module tb_test_status_monitor;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // DUT A: 10-cycle timeout, 2-cycle settle
    logic        rst_a = 1'b1, fail_a = 1'b0, finish_a = 1'b0;
    logic        done_a, pass_a, timeout_a;
    logic [1:0]  status_a;
    logic [31:0] cycles_a;

    // DUT B: no timeout, no settle, 4-bit counter
    logic        rst_b = 1'b1, fail_b = 1'b0, finish_b = 1'b0;
    logic        done_b, pass_b, timeout_b;
    logic [1:0]  status_b;
    logic [3:0]  cycles_b;

    test_status_monitor #(.TIMEOUT_CYCLES(10), .SETTLE_CYCLES(2), .CNT_W(32)) dut_a (
        .clock(clock), .reset(rst_a), .fail(fail_a), .finish(finish_a),
        .done(done_a), .pass(pass_a), .timeout(timeout_a),
        .status(status_a), .cycles(cycles_a)
    );

    test_status_monitor #(.TIMEOUT_CYCLES(0), .SETTLE_CYCLES(0), .CNT_W(4)) dut_b (
        .clock(clock), .reset(rst_b), .fail(fail_b), .finish(finish_b),
        .done(done_b), .pass(pass_b), .timeout(timeout_b),
        .status(status_b), .cycles(cycles_b)
    );

    typedef struct {
        logic [1:0]  status;
        logic        pass;
        logic        timeout;
        logic [31:0] cycles;
        int          at_cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic exp_t mk(input logic [1:0] st, input logic p, input logic to,
                                input logic [31:0] cy, input int at);
        exp_t e;
        e.status = st; e.pass = p; e.timeout = to; e.cycles = cy; e.at_cyc = at;
        return e;
    endfunction

    // Monitors: compare on the first negedge where done is seen high
    logic done_a_prev = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (done_a && !done_a_prev) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_done", 64'(done_a), 64'(1'b0));
            end else begin
                e = q_a.pop_front();
                chk("a_status",  64'(status_a),  64'(e.status));
                chk("a_pass",    64'(pass_a),    64'(e.pass));
                chk("a_timeout", 64'(timeout_a), 64'(e.timeout));
                chk("a_cycles",  64'(cycles_a),  64'(e.cycles));
                chk("a_latency", 64'(cyc),       64'(e.at_cyc));
            end
        end
        done_a_prev = done_a;
    end

    logic done_b_prev = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (done_b && !done_b_prev) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_done", 64'(done_b), 64'(1'b0));
            end else begin
                e = q_b.pop_front();
                chk("b_status",  64'(status_b),  64'(e.status));
                chk("b_pass",    64'(pass_b),    64'(e.pass));
                chk("b_timeout", 64'(timeout_b), 64'(e.timeout));
                chk("b_cycles",  64'(cycles_b),  64'(e.cycles));
                chk("b_latency", 64'(cyc),       64'(e.at_cyc));
            end
        end
        done_b_prev = done_b;
    end

    task automatic reset_a();
        rst_a = 1'b1; fail_a = 1'b0; finish_a = 1'b0;
        tick(2);
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        rst_b = 1'b1; fail_b = 1'b0; finish_b = 1'b0;
        tick(2);
        rst_b = 1'b0;
    endtask

    task automatic wait_done_a();
        int k = 0;
        while (!done_a && k < 40) begin tick(1); k++; end
        chk("a_done_wait", 64'(done_a), 64'(1'b1));
    endtask

    task automatic wait_done_b();
        int k = 0;
        while (!done_b && k < 40) begin tick(1); k++; end
        chk("b_done_wait", 64'(done_b), 64'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        chk("rst_a_done",   64'(done_a),   64'(0));
        chk("rst_a_status", 64'(status_a), 64'(0));
        chk("rst_a_cycles", 64'(cycles_a), 64'(0));
        chk("rst_b_done",   64'(done_b),   64'(0));
        chk("rst_b_pass",   64'(pass_b),   64'(0));
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Clean pass: finish at RUN cycle 5
        tick(5);
        chk("a_running_status", 64'(status_a), 64'(0));
        finish_a = 1'b1;
        q_a.push_back(mk(2'b01, 1'b1, 1'b0, 32'd5, cyc + 3));
        tick(1); finish_a = 1'b0;
        wait_done_a();

        // Late fail during settle, then a fail pulse after DONE
        reset_a();
        tick(3);
        finish_a = 1'b1;
        q_a.push_back(mk(2'b10, 1'b0, 1'b0, 32'd3, cyc + 3));
        tick(1); finish_a = 1'b0; fail_a = 1'b1;
        tick(1); fail_a = 1'b0;
        wait_done_a();
        fail_a = 1'b1; finish_a = 1'b1;
        tick(2); fail_a = 1'b0; finish_a = 1'b0;
        tick(1);
        chk("a_sticky_status", 64'(status_a), 64'(2'b10));
        chk("a_sticky_done",   64'(done_a),   64'(1));
        chk("a_sticky_cycles", 64'(cycles_a), 64'(3));

        // Timeout with no activity
        reset_a();
        q_a.push_back(mk(2'b11, 1'b0, 1'b1, 32'd9, cyc + 10));
        wait_done_a();

        // Race: fail and finish in the same cycle
        reset_a();
        tick(2);
        fail_a = 1'b1; finish_a = 1'b1;
        q_a.push_back(mk(2'b10, 1'b0, 1'b0, 32'd2, cyc + 3));
        tick(1); fail_a = 1'b0; finish_a = 1'b0;
        wait_done_a();

        // Race: finish on the timeout-threshold cycle
        reset_a();
        tick(9);
        finish_a = 1'b1;
        q_a.push_back(mk(2'b01, 1'b1, 1'b0, 32'd9, cyc + 3));
        tick(1); finish_a = 1'b0;
        wait_done_a();

        // Race: fail on the timeout-threshold cycle
        reset_a();
        tick(9);
        fail_a = 1'b1;
        q_a.push_back(mk(2'b11, 1'b0, 1'b1, 32'd9, cyc + 1));
        tick(1); fail_a = 1'b0;
        wait_done_a();

        // Reset mid-run clears an earlier fail
        reset_a();
        tick(4);
        fail_a = 1'b1;
        tick(1); fail_a = 1'b0;
        tick(1);
        chk("a_midrun_done", 64'(done_a), 64'(0));
        reset_a();
        tick(3);
        finish_a = 1'b1;
        q_a.push_back(mk(2'b01, 1'b1, 1'b0, 32'd3, cyc + 3));
        tick(1); finish_a = 1'b0;
        wait_done_a();

        // No timeout, no settle: counter saturates, finish then passes next cycle
        reset_b();
        tick(40);
        chk("b_sat_cycles", 64'(cycles_b), 64'(15));
        chk("b_sat_done",   64'(done_b),   64'(0));
        chk("b_sat_status", 64'(status_b), 64'(0));
        finish_b = 1'b1;
        q_b.push_back(mk(2'b01, 1'b1, 1'b0, 32'd15, cyc + 1));
        tick(1); finish_b = 1'b0;
        wait_done_b();

        // No settle: earlier fail pulse still yields FAIL
        reset_b();
        tick(1);
        fail_b = 1'b1;
        tick(1); fail_b = 1'b0;
        tick(1);
        finish_b = 1'b1;
        q_b.push_back(mk(2'b10, 1'b0, 1'b0, 32'd3, cyc + 1));
        tick(1); finish_b = 1'b0;
        wait_done_b();

        tick(3);
        chk("a_queue_drained", 64'(q_a.size()), 64'(0));
        chk("b_queue_drained", 64'(q_b.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
